period_to_freq_div: RTL and testbench

PERIOD_TO_FREQ_DIV -- requirements
Module: period_to_freq_div

---
 rtl/period_to_freq_div_pkg.sv | 9 +
 rtl/period_to_freq_div_div_step.sv | 18 +
 rtl/period_to_freq_div.sv | 84 ++++++++
 tb/tb_period_to_freq_div.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/period_to_freq_div_pkg.sv
// period_to_freq_div_pkg: shared widths, counter/display constants and divider FSM states
package period_to_freq_div_pkg;
   localparam int DVND_W_DEF = 20;
   localparam int DVSR_W_DEF = 10;
   localparam int CLK_HZ     = 100_000_000;
   localparam int US_TICKS   = CLK_HZ / 1_000_000;
   localparam int BCD_DIGITS = 4;
   typedef enum logic [1:0] {IDLE, OP, LAST, DONE} state_t;
endpackage

// File: rtl/period_to_freq_div_div_step.sv
// div_step: one restoring shift-subtract iteration, purely combinational
module div_step
   import period_to_freq_div_pkg::*;
#(
   parameter int DVSR_W = DVSR_W_DEF
) (
   input  logic [DVSR_W-1:0] rmd_in,
   input  logic              msb,
   input  logic [DVSR_W-1:0] dvsr,
   output logic [DVSR_W-1:0] rmd_out,
   output logic              q_bit
);
   logic [DVSR_W:0] trial, diff;
   assign trial   = {rmd_in, msb};
   assign diff    = trial - {1'b0, dvsr};
   assign q_bit   = trial >= {1'b0, dvsr};
   assign rmd_out = DVSR_W'(q_bit ? diff : trial);
endmodule

// File: rtl/period_to_freq_div.sv
// period_to_freq_div: sequential unsigned divider turning a measured period into a frequency
module period_to_freq_div
   import period_to_freq_div_pkg::*;
#(
   parameter int DVND_W = DVND_W_DEF,
   parameter int DVSR_W = DVSR_W_DEF
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [DVND_W-1:0] dvnd,
   input  logic [DVSR_W-1:0] dvsr,
   output logic              ready,
   output logic              done_tick,
   output logic [DVND_W-1:0] quo,
   output logic [DVSR_W-1:0] rmd,
   output logic              dz_err
);
   localparam int CNT_W = $clog2(DVND_W);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DVND_W - 2);
   state_t            state, state_nxt;
   logic [DVND_W-1:0] dvnd_reg;
   logic [DVSR_W-1:0] dvsr_reg, rmd_work, rmd_nxt;
   logic [CNT_W-1:0]  cnt;
   logic              q_bit;
   div_step #(.DVSR_W(DVSR_W)) u_step (
      .rmd_in (rmd_work),
      .msb    (dvnd_reg[DVND_W-1]),
      .dvsr   (dvsr_reg),
      .rmd_out(rmd_nxt),
      .q_bit  (q_bit)
   );
   // state register
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   // next state: a zero divisor short-circuits to DONE after one OP cycle
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = start ? OP : IDLE;
         OP:      state_nxt = (dvsr_reg == '0) ? DONE : (cnt == CNT_LAST) ? LAST : OP;
         LAST:    state_nxt = DONE;
         default: state_nxt = IDLE;
      endcase
   end
   // datapath: quotient bits shift into the dividend register; results publish only on entry to DONE
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         dvnd_reg <= '0;
         dvsr_reg <= '0;
         rmd_work <= '0;
         cnt      <= '0;
         quo      <= '0;
         rmd      <= '0;
         dz_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) begin
               dvnd_reg <= dvnd;
               dvsr_reg <= dvsr;
               rmd_work <= '0;
               cnt      <= '0;
               dz_err   <= 1'b0;
            end
            OP, LAST: if (dvsr_reg == '0) begin
               quo    <= '1;
               rmd    <= '0;
               dz_err <= 1'b1;
            end else begin
               dvnd_reg <= {dvnd_reg[DVND_W-2:0], q_bit};
               rmd_work <= rmd_nxt;
               cnt      <= cnt + CNT_W'(1);
               if (state == LAST) begin
                  quo <= {dvnd_reg[DVND_W-2:0], q_bit};
                  rmd <= rmd_nxt;
               end
            end
            default: ;
         endcase
      end
   assign ready     = state == IDLE;
   assign done_tick = state == DONE;
endmodule

// File: tb/tb_period_to_freq_div.sv
// tb_period_to_freq_div: randomized scoreboard bench against an arithmetic reference model
module tb_period_to_freq_div;
   localparam int DW = 20;
   localparam int SW = 10;
   typedef struct {
      logic [DW-1:0] q;
      logic [SW-1:0] r;
      logic          dz;
      int            due;
   } exp_t;
   logic          clk = 0, reset_n = 1, start = 0;
   logic [DW-1:0] dvnd = '0, quo;
   logic [SW-1:0] dvsr = '0, rmd;
   logic          ready, done_tick, dz_err;
   exp_t          sb[$];
   exp_t          got;
   int            cyc = 0, n_pass = 0, n_tot = 0;
   logic [DW-1:0] held_q = '0;
   logic [SW-1:0] held_r = '0;

   period_to_freq_div #(.DVND_W(DW), .DVSR_W(SW)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .dvnd(dvnd), .dvsr(dvsr),
      .ready(ready), .done_tick(done_tick), .quo(quo), .rmd(rmd), .dz_err(dz_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // monitor: pops the scoreboard on every done_tick, otherwise checks outputs stay put
   always @(negedge clk) if (reset_n) begin
      if (done_tick) begin
         if (sb.size() == 0) chk("done with empty scoreboard", sb.size(), 1);
         else begin
            got = sb.pop_front();
            chk("latency", cyc, got.due);
            chk("quo", quo, got.q);
            chk("rmd", rmd, got.r);
            chk("dz_err", dz_err, got.dz);
            held_q = got.q;
            held_r = got.r;
         end
      end else begin
         chk("quo hold", quo, held_q);
         chk("rmd hold", rmd, held_r);
         if (sb.size() > 0 && cyc > sb[0].due) begin
            chk("done timeout", cyc, sb[0].due);
            void'(sb.pop_front());
         end
      end
   end

   task automatic issue(input logic [DW-1:0] a, input logic [SW-1:0] b);
      exp_t e;
      int w = 0;
      while (!ready && w < 100) begin
         @(negedge clk);
         w++;
      end
      chk("ready before start", ready, 1);
      start = 1;
      dvnd  = a;
      dvsr  = b;
      e.dz  = b == 0;
      e.q   = e.dz ? '1 : a / DW'(b);
      e.r   = e.dz ? '0 : SW'(a % DW'(b));
      e.due = cyc + (e.dz ? 2 : DW + 1);
      sb.push_back(e);
      @(negedge clk);
      start = 0;
      dvnd  = DW'($urandom);
      dvsr  = SW'($urandom);
      chk("ready low after start", ready, 0);
      chk("dz_err cleared on start", dz_err, 0);
   endtask

   initial begin
      logic [DW-1:0] a;
      logic [SW-1:0] b;
      int w;
      #2 reset_n = 0;
      repeat (2) @(negedge clk);
      chk("reset ready", ready, 1);
      chk("reset done_tick", done_tick, 0);
      chk("reset quo", quo, 0);
      chk("reset rmd", rmd, 0);
      chk("reset dz_err", dz_err, 0);
      reset_n = 1;
      @(negedge clk);
      issue(20'd1_000_000, 10'd500);
      issue(20'd1_000_000, 10'd1023);
      issue(20'hABCDE, 10'd1);
      issue(20'd0, 10'd7);
      issue(20'd12345, 10'd0);
      issue(20'd1_000_000, 10'd3);
      issue(20'd0, 10'd0);
      issue(20'hFFFFF, 10'd1023);
      issue(20'd1_000_000, 10'd500);
      repeat (3) @(negedge clk);
      start = 1;
      dvnd  = 20'd7;
      dvsr  = 10'd3;
      @(negedge clk);
      start = 0;
      issue(20'd999_999, 10'd777);
      repeat (8) @(negedge clk);
      reset_n = 0;
      sb.delete();
      held_q = '0;
      held_r = '0;
      #1;
      chk("mid-op reset ready", ready, 1);
      chk("mid-op reset done_tick", done_tick, 0);
      chk("mid-op reset quo", quo, 0);
      chk("mid-op reset rmd", rmd, 0);
      chk("mid-op reset dz_err", dz_err, 0);
      repeat (3) @(negedge clk);
      chk("no done during reset", done_tick, 0);
      reset_n = 1;
      @(negedge clk);
      issue(20'd54321, 10'd99);
      repeat (30) begin
         a = DW'($urandom);
         b = ($urandom_range(0, 7) == 0) ? '0 : SW'($urandom);
         issue(a, b);
      end
      w = 0;
      while (sb.size() != 0 && w < 100) begin
         @(negedge clk);
         w++;
      end
      chk("scoreboard drained", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
